// File: rtl/rs_stream_pkg.sv
// rs_stream_pkg: shared defaults, derived sizes and FSM state type for the RS codeword framer
package rs_stream_pkg;
    localparam int def_word_length = 8;
    localparam int def_n = 15;
    localparam int def_k = 11;
    localparam int def_idx_w = $clog2(def_n);
    localparam int def_depth = 2 * def_n;
    typedef enum logic {st_idle, st_send} framer_state_t;
endpackage

// File: rtl/rs_framer_mem.sv
// rs_framer_mem: depth x word_length symbol store, one synchronous write port, one asynchronous read port
// Ports: clk; we/waddr/wdata write port; raddr/rdata combinational read port.
module rs_framer_mem
    import rs_stream_pkg::*;
#(
    parameter int word_length = def_word_length,
    parameter int depth = def_depth,
    parameter int aw = $clog2(depth)
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [aw-1:0]          waddr,
    input  logic [word_length-1:0] wdata,
    input  logic [aw-1:0]          raddr,
    output logic [word_length-1:0] rdata
);
    logic [word_length-1:0] mem [depth];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/rs_codeword_framer.sv
// rs_codeword_framer: store-and-forward framer buffering up to two n-symbol codewords
// Ports: clk; rst (asynchronous, active-low); i_valid/i_symbol/o_in_ready upstream side;
//   o_valid/o_symbol/o_start_codeword/o_end_codeword/i_consume downstream side.
// Define RS_FRAMER_ABORT_EN to add i_abort, which drops the partial codeword being written.
module rs_codeword_framer
    import rs_stream_pkg::*;
#(
    parameter int word_length = def_word_length,
    parameter int n = def_n,
    parameter int k = def_k
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef RS_FRAMER_ABORT_EN
    input  logic                   i_abort,
`endif
    input  logic                   i_valid,
    input  logic [word_length-1:0] i_symbol,
    output logic                   o_in_ready,
    output logic                   o_valid,
    output logic [word_length-1:0] o_symbol,
    output logic                   o_start_codeword,
    output logic                   o_end_codeword,
    input  logic                   i_consume
);
    localparam int iw = $clog2(n);
    localparam int depth = 2 * n;
    localparam int pw = $clog2(depth);
    localparam int ow = $clog2(depth + 1);
    if (k >= n || k < 1) begin : g_bad_k
        $error("rs_codeword_framer: k must satisfy 1 <= k < n");
    end
    framer_state_t state;
    logic [pw-1:0] wr_ptr, rd_ptr;
    logic [iw-1:0] wr_idx, rd_idx;
    logic [1:0] cw_cnt;
    logic [ow-1:0] occ;
    logic [word_length-1:0] rd_data;
    logic wr, rd, cw_done, cw_read, abort;
`ifdef RS_FRAMER_ABORT_EN
    assign abort = i_abort;
`else
    assign abort = 1'b0;
`endif
    assign o_in_ready = occ < ow'(depth);
    assign o_valid = state == st_send;
    assign wr = i_valid && o_in_ready && !abort;
    assign rd = o_valid && i_consume;
    assign cw_done = wr && wr_idx == iw'(n - 1);
    assign cw_read = rd && rd_idx == iw'(n - 1);
    assign o_symbol = o_valid ? rd_data : '0;
    assign o_start_codeword = o_valid && rd_idx == '0;
    assign o_end_codeword = o_valid && rd_idx == iw'(n - 1);
    rs_framer_mem #(.word_length(word_length), .depth(depth)) u_mem (
        .clk(clk), .we(wr), .waddr(wr_ptr), .wdata(i_symbol), .raddr(rd_ptr), .rdata(rd_data)
    );
    // A codeword completing this cycle counts immediately, so SEND starts the cycle after
    // the n-th write and a codeword finishing on the read side can roll straight into it.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= st_idle;
            wr_ptr <= '0;
            rd_ptr <= '0;
            wr_idx <= '0;
            rd_idx <= '0;
            cw_cnt <= '0;
            occ <= '0;
        end else begin
            if (abort) begin
                wr_idx <= '0;
                wr_ptr <= (wr_ptr >= pw'(wr_idx)) ? wr_ptr - pw'(wr_idx) : wr_ptr + pw'(depth) - pw'(wr_idx);
            end else if (wr) begin
                wr_idx <= cw_done ? '0 : wr_idx + iw'(1);
                wr_ptr <= (wr_ptr == pw'(depth - 1)) ? '0 : wr_ptr + pw'(1);
            end
            if (rd) begin
                rd_idx <= cw_read ? '0 : rd_idx + iw'(1);
                rd_ptr <= (rd_ptr == pw'(depth - 1)) ? '0 : rd_ptr + pw'(1);
            end
            occ <= occ + ow'(wr) - ow'(rd) - (abort ? ow'(wr_idx) : ow'(0));
            cw_cnt <= cw_cnt + 2'(cw_done) - 2'(cw_read);
            state <= (state == st_idle) ? ((cw_cnt != '0 || cw_done) ? st_send : st_idle)
                                        : ((cw_read && cw_cnt == 2'd1 && !cw_done) ? st_idle : st_send);
        end
endmodule

// File: tb/tb_rs_codeword_framer.sv
// tb_rs_codeword_framer: scoreboard bench for rs_codeword_framer with directed vectors
module tb_rs_codeword_framer;
    localparam int N = 15;
    typedef struct {logic [7:0] sym; logic st; logic en;} exp_t;
    logic clk = 0, rst = 0, i_valid = 0, i_consume = 0;
    logic [7:0] i_symbol = 0;
    logic o_in_ready, o_valid, o_start_codeword, o_end_codeword;
    logic [7:0] o_symbol;
`ifdef RS_FRAMER_ABORT_EN
    logic i_abort = 0;
`endif
    int checks = 0, failures = 0;
    exp_t exp_q[$];
    logic [7:0] pend[$];
    always #5 clk = ~clk;
    rs_codeword_framer dut (
        .clk(clk), .rst(rst),
`ifdef RS_FRAMER_ABORT_EN
        .i_abort(i_abort),
`endif
        .i_valid(i_valid), .i_symbol(i_symbol), .o_in_ready(o_in_ready),
        .o_valid(o_valid), .o_symbol(o_symbol), .o_start_codeword(o_start_codeword),
        .o_end_codeword(o_end_codeword), .i_consume(i_consume)
    );
    task automatic chk(input string nm, input int act, input int want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, want);
        end
    endtask
    // Monitor: every presented symbol must match the scoreboard front; pop on transfer.
    always @(negedge clk)
        if (rst && o_valid) begin
            if (exp_q.size() == 0) chk("unexpected_output", int'(o_symbol), -1);
            else begin
                chk("out_symbol", int'(o_symbol), int'(exp_q[0].sym));
                chk("out_start", int'(o_start_codeword), int'(exp_q[0].st));
                chk("out_end", int'(o_end_codeword), int'(exp_q[0].en));
                if (i_consume) void'(exp_q.pop_front());
            end
        end
    task automatic put(input logic [7:0] s, input logic acc);
        i_valid = 1;
        i_symbol = s;
        chk("in_ready", int'(o_in_ready), int'(acc));
        if (acc) begin
            pend.push_back(s);
            if (pend.size() == N) begin
                for (int i = 0; i < N; i++) exp_q.push_back('{sym: pend[i], st: (i == 0), en: (i == N - 1)});
                pend.delete();
            end
        end
        @(posedge clk);
        #1;
        i_valid = 0;
    endtask
    task automatic drain(output int c);
        c = 0;
        i_consume = 1;
        while (exp_q.size() != 0 && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("drain_empty", exp_q.size(), 0);
        chk("idle_after_drain", int'(o_valid), 0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end
    initial begin
        int c;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_ready", int'(o_in_ready), 1);
        chk("rst_symbol", int'(o_symbol), 0);
        chk("rst_start", int'(o_start_codeword), 0);
        chk("rst_end", int'(o_end_codeword), 0);
        rst = 1;
        @(posedge clk);
        #1;
        // One codeword, consumer always ready: 15 back-to-back outputs right after the 15th write
        i_consume = 1;
        for (int i = 1; i <= N; i++) put(8'(i), 1);
        for (int i = 0; i < N; i++) begin
            chk("single_cw_valid", int'(o_valid), 1);
            @(posedge clk);
            #1;
        end
        chk("single_cw_idle", int'(o_valid), 0);
        // Fill both codewords with no consumption, then one transfer reopens input
        i_consume = 0;
        for (int i = 0; i < 2 * N; i++) put(8'(8'h20 + i), 1);
        chk("full_ready", int'(o_in_ready), 0);
        put(8'hFF, 0);
        i_consume = 1;
        @(posedge clk);
        #1;
        i_consume = 0;
        chk("ready_after_transfer", int'(o_in_ready), 1);
        drain(c);
        chk("two_cw_back_to_back", c, 2 * N - 1);
        // Writes overlapping transfers
        i_consume = 1;
        for (int i = 0; i < 2 * N; i++) put(8'(8'h40 + i), 1);
        drain(c);
        // Stall for 5 cycles at read index 7
        i_consume = 0;
        for (int i = 0; i < N; i++) put(8'(8'h60 + i), 1);
        i_consume = 1;
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        i_consume = 0;
        repeat (5) begin
            chk("hold_symbol", int'(o_symbol), 8'h67);
            @(posedge clk);
            #1;
        end
        drain(c);
        chk("stall_drain_cycles", c, N - 7);
        // Asynchronous reset with one codeword presenting and a partial one stored
        i_consume = 0;
        for (int i = 0; i < N; i++) put(8'(8'h70 + i), 1);
        for (int i = 0; i < 8; i++) put(8'(8'h90 + i), 1);
        chk("pre_reset_valid", int'(o_valid), 1);
        #2;
        rst = 0;
        #1;
        exp_q.delete();
        pend.delete();
        chk("async_rst_valid", int'(o_valid), 0);
        chk("async_rst_symbol", int'(o_symbol), 0);
        chk("async_rst_start", int'(o_start_codeword), 0);
        chk("async_rst_ready", int'(o_in_ready), 1);
        @(posedge clk);
        #1;
        rst = 1;
        i_consume = 1;
        repeat (20) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) put(8'(8'h80 + i), 1);
        drain(c);
`ifdef RS_FRAMER_ABORT_EN
        i_consume = 1;
        for (int i = 0; i < 6; i++) put(8'(8'hA0 + i), 1);
        i_abort = 1;
        @(posedge clk);
        #1;
        i_abort = 0;
        pend.delete();
        for (int i = 0; i < N; i++) put(8'(8'hB0 + i), 1);
        drain(c);
        chk("abort_drain_cycles", c, N);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
